// File: rtl/alu_logic_stage_16bit_pkg.sv
// Shared opcode encodings and default widths for the ALU logic-operation stage.
package alu_logic_stage_16bit_pkg;

    localparam int unsigned WIDTH_DEF     = 16;
    localparam int unsigned CNT_WIDTH_DEF = 16;
    localparam int unsigned OP_WIDTH      = 2;

    localparam logic [OP_WIDTH-1:0] OP_NOT = 2'b00;
    localparam logic [OP_WIDTH-1:0] OP_AND = 2'b01;
    localparam logic [OP_WIDTH-1:0] OP_OR  = 2'b10;
    localparam logic [OP_WIDTH-1:0] OP_XOR = 2'b11;

endpackage

// File: rtl/alu_logic_comb_16bit.sv
// Purely combinational logic unit: y = op(a, b) for NOT A / AND / OR / XOR.
module alu_logic_comb_16bit
    import alu_logic_stage_16bit_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic [OP_WIDTH-1:0] op,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    output logic [WIDTH-1:0]    y
);

    logic [WIDTH-1:0] not_a;

    // Inverter path shared with the standalone 16-bit NOT gate behaviour.
    assign not_a = ~a;

    always_comb begin
        y = '0;
        case (op)
            OP_NOT:  y = not_a;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_logic_stage_16bit.sv
// Registered logic-operation stage: main + skid registers behind a valid/ready
// handshake, registered zero/negative flags and a completed-transfer counter.
module alu_logic_stage_16bit
    import alu_logic_stage_16bit_pkg::*;
#(
    parameter int unsigned WIDTH     = WIDTH_DEF,
    parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [OP_WIDTH-1:0]  in_op,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_y,
    output logic                 out_zero,
    output logic                 out_neg,
    output logic [CNT_WIDTH-1:0] xfer_count
);

    logic [WIDTH-1:0]     new_y;
    logic                 new_zero;
    logic                 new_neg;

    logic                 main_valid_q, main_valid_d;
    logic [WIDTH-1:0]     main_y_q,     main_y_d;
    logic                 main_zero_q,  main_zero_d;
    logic                 main_neg_q,   main_neg_d;

    logic                 skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0]     skid_y_q,     skid_y_d;
    logic                 skid_zero_q,  skid_zero_d;
    logic                 skid_neg_q,   skid_neg_d;

    logic                 ready_q,      ready_d;
    logic [CNT_WIDTH-1:0] cnt_q,        cnt_d;

    logic                 in_hs;
    logic                 out_hs;

    alu_logic_comb_16bit #(
        .WIDTH (WIDTH)
    ) u_comb (
        .op (in_op),
        .a  (in_a),
        .b  (in_b),
        .y  (new_y)
    );

    // Flags are frozen alongside the result at capture time.
    assign new_zero = (new_y == '0);
    assign new_neg  = new_y[WIDTH-1];

    assign in_hs  = in_valid && in_ready;
    assign out_hs = main_valid_q && out_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        main_y_d     = main_y_q;
        main_zero_d  = main_zero_q;
        main_neg_d   = main_neg_q;
        skid_valid_d = skid_valid_q;
        skid_y_d     = skid_y_q;
        skid_zero_d  = skid_zero_q;
        skid_neg_d   = skid_neg_q;
        cnt_d        = cnt_q;

        if (out_hs) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
            if (skid_valid_q) begin
                // in_ready was low, so no new beat can arrive this cycle.
                main_y_d     = skid_y_q;
                main_zero_d  = skid_zero_q;
                main_neg_d   = skid_neg_q;
                skid_valid_d = 1'b0;
            end else if (in_hs) begin
                main_y_d     = new_y;
                main_zero_d  = new_zero;
                main_neg_d   = new_neg;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (in_hs) begin
            if (!main_valid_q) begin
                main_valid_d = 1'b1;
                main_y_d     = new_y;
                main_zero_d  = new_zero;
                main_neg_d   = new_neg;
            end else begin
                skid_valid_d = 1'b1;
                skid_y_d     = new_y;
                skid_zero_d  = new_zero;
                skid_neg_d   = new_neg;
            end
        end

        ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_y_q     <= '0;
            main_zero_q  <= 1'b0;
            main_neg_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_y_q     <= '0;
            skid_zero_q  <= 1'b0;
            skid_neg_q   <= 1'b0;
            ready_q      <= 1'b1;
            cnt_q        <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_y_q     <= main_y_d;
            main_zero_q  <= main_zero_d;
            main_neg_q   <= main_neg_d;
            skid_valid_q <= skid_valid_d;
            skid_y_q     <= skid_y_d;
            skid_zero_q  <= skid_zero_d;
            skid_neg_q   <= skid_neg_d;
            ready_q      <= ready_d;
            cnt_q        <= cnt_d;
        end
    end

    // Reset gating keeps in_ready low while rst is held, independent of out_ready.
    assign in_ready   = ready_q && !rst;
    assign out_valid  = main_valid_q;
    assign out_y      = main_y_q;
    assign out_zero   = main_zero_q;
    assign out_neg    = main_neg_q;
    assign xfer_count = cnt_q;

endmodule

// File: tb/tb_alu_logic_stage_16bit.sv
// Scoreboard bench for alu_logic_stage_16bit: directed cases, random handshakes, counter wrap.
module tb_alu_logic_stage_16bit;

    localparam int unsigned W  = 16;
    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    in_op = 2'b00;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_y;
    logic          out_zero;
    logic          out_neg;
    logic [CW-1:0] xfer_count;

    alu_logic_stage_16bit #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_y      (out_y),
        .out_zero   (out_zero),
        .out_neg    (out_neg),
        .xfer_count (xfer_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] y;
        logic         zero;
        logic         neg;
    } exp_t;

    exp_t          sbq[$];
    int            n_cmp  = 0;
    int            n_fail = 0;
    int            n_push = 0;
    int            cycles = 0;
    int unsigned   model_cnt = 0;
    logic          prev_stall = 1'b0;
    logic [W-1:0]  prev_y = '0;
    logic          prev_zero = 1'b0;
    logic          prev_neg = 1'b0;

    function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        case (op)
            2'd0:    e.y = ~a;
            2'd1:    e.y = a & b;
            2'd2:    e.y = a | b;
            default: e.y = a ^ b;
        endcase
        e.zero = (e.y == 0);
        e.neg  = (e.y >= 16'h8000);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: sample at negedge, check occupancy/counter/stability, pop and push scoreboard.
    always @(negedge clk) begin
        exp_t e;
        cycles++;
        if (cycles > 150000) begin
            $display("FAIL watchdog: got %0d cycles expected under 150000", cycles);
            $fatal(1, "watchdog expired");
        end
        if (rst) begin
            sbq.delete();
            model_cnt  = 0;
            prev_stall = 1'b0;
        end else begin
            check("out_valid", 32'(out_valid), 32'(sbq.size() > 0));
            check("in_ready", 32'(in_ready), 32'(sbq.size() < 2));
            check("xfer_count", 32'(xfer_count), model_cnt % 65536);
            if (prev_stall && out_valid) begin
                check("stall_y", 32'(out_y), 32'(prev_y));
                check("stall_flags", {30'd0, out_zero, out_neg}, {30'd0, prev_zero, prev_neg});
            end
            if (out_valid && out_ready && sbq.size() > 0) begin
                e = sbq.pop_front();
                check("out_y", 32'(out_y), 32'(e.y));
                check("out_zero", 32'(out_zero), 32'(e.zero));
                check("out_neg", 32'(out_neg), 32'(e.neg));
                model_cnt++;
            end
            if (in_valid && in_ready) begin
                sbq.push_back(model(in_op, in_a, in_b));
                n_push++;
            end
            prev_stall = out_valid && !out_ready;
            prev_y     = out_y;
            prev_zero  = out_zero;
            prev_neg   = out_neg;
        end
    end

    task automatic do_reset(input int n);
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic send(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bit acc = 1'b0;
        in_valid = 1'b1;
        in_op = op;
        in_a  = a;
        in_b  = b;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("send_accepted", 32'(acc), 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 50 && sbq.size() != 0; i++) @(posedge clk);
        #1;
        check("drain_empty", 32'(sbq.size()), 32'd0);
    endtask

    initial begin
        int base;
        do_reset(2);

        // Single NOT beat.
        out_ready = 1'b1;
        send(2'b00, 16'h0000, 16'h1234);
        idle(3);
        @(negedge clk);
        check("xfer_after_single", 32'(xfer_count), 32'd1);
        @(posedge clk); #1;

        // Back-to-back AND/OR/XOR.
        send(2'b01, 16'hAAAA, 16'h5555);
        send(2'b10, 16'hAAAA, 16'h5555);
        send(2'b11, 16'hAAAA, 16'h5555);
        idle(3);

        // Backpressure: main held, second beat in skid.
        out_ready = 1'b0;
        send(2'b00, 16'h5555, 16'h0000);
        send(2'b00, 16'hFFFF, 16'h0000);
        @(negedge clk);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_held_y", 32'(out_y), 32'h0000_AAAA);
        @(posedge clk); #1;
        out_ready = 1'b1;
        idle(4);

        // Reset with both registers full.
        out_ready = 1'b0;
        send(2'b01, 16'hF0F0, 16'hFF00);
        send(2'b10, 16'h0F0F, 16'h00F0);
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_y", 32'(out_y), 32'd0);
        check("rst_flags", {30'd0, out_zero, out_neg}, 32'd0);
        check("rst_xfer", 32'(xfer_count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        out_ready = 1'b1;
        send(2'b11, 16'h8001, 16'h0001);
        idle(3);

        // Random valid/ready traffic, 1000 beats.
        do_reset(1);
        base = n_push;
        for (int c = 0; c < 20000 && (n_push - base) < 1000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_op     = 2'($urandom_range(0, 3));
            in_a      = W'($urandom);
            in_b      = ($urandom_range(0, 7) == 0) ? in_a : W'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("random_beats", 32'(n_push - base), 32'd1000);
        drain();
        @(negedge clk);
        check("xfer_after_random", 32'(xfer_count), 32'd1000);
        @(posedge clk); #1;

        // Counter wrap: 65536 full-throughput handshakes.
        do_reset(1);
        base = n_push;
        out_ready = 1'b1;
        for (int c = 0; c < 70000 && (n_push - base) < 65536; c++) begin
            in_valid = 1'b1;
            in_op    = 2'($urandom_range(0, 3));
            in_a     = W'($urandom);
            in_b     = W'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("wrap_beats", 32'(n_push - base), 32'd65536);
        drain();
        @(negedge clk);
        check("xfer_wrap", 32'(xfer_count), 32'd0);
        @(posedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
